// File: rtl/gnn_pkg.sv
// Shared types for the GNN accelerator control path: scheduler state
// encoding, default node count and the node index type.
package gnn_pkg;

  localparam int NUM_NODES_DEF = 4;
  localparam int TIMEOUT_DEF   = 16;
  localparam int NODE_W_DEF    = $clog2(NUM_NODES_DEF);

  typedef logic [NODE_W_DEF-1:0] node_idx_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/gnn_wait_timer.sv
// Loadable wait counter: clr_i restarts it at zero, en_i advances it by one,
// tc_o flags that the count has reached TIMEOUT-1.
module gnn_wait_timer
  import gnn_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/gnn_node_mac_scheduler.sv
// Time-multiplexes one shared MAC stage across all graph nodes: launch,
// wait for result, write result register, in ascending node order, then
// pulse pass completion. Watchdog and overrun flags are sticky per pass.
// All outputs are registered, decoded from the next state.
module gnn_node_mac_scheduler
  import gnn_pkg::*;
#(
  parameter  int NUM_NODES = NUM_NODES_DEF,
  parameter  int TIMEOUT   = TIMEOUT_DEF,
  localparam int NODE_W    = $clog2(NUM_NODES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_ready,
  output logic                 mac_in_ready,
  input  logic                 mac_out_ready,
  output logic [NODE_W-1:0]    node_sel,
  output logic [NUM_NODES-1:0] wr_en,
  output logic                 busy,
  output logic                 out_ready,
  output logic                 err_timeout,
  output logic                 err_overrun
);

  sched_state_t         state_q, state_d;
  logic [NODE_W-1:0]    node_q, node_d;
  logic                 err_to_q, err_to_d;
  logic                 err_ov_q, err_ov_d;
  logic                 mac_in_q, mac_in_d;
  logic [NODE_W-1:0]    sel_q, sel_d;
  logic [NUM_NODES-1:0] wr_en_q, wr_en_d;
  logic                 busy_q, busy_d;
  logic                 out_q, out_d;
  logic                 tmr_clr_s, tmr_en_s, tmr_tc_s;

  gnn_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (tmr_clr_s),
    .en_i  (tmr_en_s),
    .tc_o  (tmr_tc_s)
  );

  // Next-state, node index, sticky errors and timer control.
  always_comb begin
    state_d   = state_q;
    node_d    = node_q;
    err_to_d  = err_to_q;
    err_ov_d  = err_ov_q;
    tmr_clr_s = 1'b0;
    tmr_en_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        node_d = {NODE_W{1'b0}};
        if (in_ready) begin
          state_d  = S_ISSUE;
          err_to_d = 1'b0;
          err_ov_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        tmr_clr_s = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the timeout cycle still counts as done.
        if (mac_out_ready) begin
          state_d = S_WRITE;
        end else if (tmr_tc_s) begin
          err_to_d = 1'b1;
          node_d   = {NODE_W{1'b0}};
          state_d  = S_IDLE;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      S_WRITE: begin
        if (node_q == NODE_W'(NUM_NODES - 1)) begin
          state_d = S_DONE;
        end else begin
          node_d  = node_q + NODE_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        node_d  = {NODE_W{1'b0}};
        state_d = S_IDLE;
      end
      default: begin
        node_d  = {NODE_W{1'b0}};
        state_d = S_IDLE;
      end
    endcase
    // A start request while a pass is running is flagged, never acted on.
    if ((state_q != S_IDLE) && in_ready) begin
      err_ov_d = 1'b1;
    end else begin
      err_ov_d = err_ov_d;
    end
  end

  // Output decode from the upcoming state so outputs come straight from flops.
  always_comb begin
    mac_in_d = (state_d == S_ISSUE);
    sel_d    = (state_d == S_IDLE) ? {NODE_W{1'b0}} : node_d;
    wr_en_d  = (state_d == S_WRITE) ? ({{(NUM_NODES-1){1'b0}}, 1'b1} << node_d)
                                    : {NUM_NODES{1'b0}};
    busy_d   = (state_d != S_IDLE);
    out_d    = (state_d == S_DONE);
  end

  // State, node index, error flags and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      node_q   <= {NODE_W{1'b0}};
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
      mac_in_q <= 1'b0;
      sel_q    <= {NODE_W{1'b0}};
      wr_en_q  <= {NUM_NODES{1'b0}};
      busy_q   <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      node_q   <= node_d;
      err_to_q <= err_to_d;
      err_ov_q <= err_ov_d;
      mac_in_q <= mac_in_d;
      sel_q    <= sel_d;
      wr_en_q  <= wr_en_d;
      busy_q   <= busy_d;
      out_q    <= out_d;
    end
  end

  assign mac_in_ready = mac_in_q;
  assign node_sel     = sel_q;
  assign wr_en        = wr_en_q;
  assign busy         = busy_q;
  assign out_ready    = out_q;
  assign err_timeout  = err_to_q;
  assign err_overrun  = err_ov_q;

endmodule

// File: tb/tb_gnn_node_mac_scheduler.sv
// Directed bench for gnn_node_mac_scheduler with a behavioural MAC model
// whose per-node latency is set per pass (0 = never returns).
module tb_gnn_node_mac_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_ready;
  logic       mac_in_ready;
  logic       mac_out_ready;
  logic [1:0] node_sel;
  logic [3:0] wr_en;
  logic       busy;
  logic       out_ready;
  logic       err_timeout;
  logic       err_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  // MAC model
  int   lat_tbl [4];
  int   mac_cnt = 0;
  logic mac_model = 1'b0;
  logic spur = 1'b0;

  // Monitor logs, relative to t0
  int   launch_cyc [8];
  int   launch_node [8];
  int   wr_cyc [8];
  int   wr_val [8];
  int   n_launch, n_wr, n_out, out_cyc, to_cyc, busy_low;

  gnn_node_mac_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_ready      (in_ready),
    .mac_in_ready  (mac_in_ready),
    .mac_out_ready (mac_out_ready),
    .node_sel      (node_sel),
    .wr_en         (wr_en),
    .busy          (busy),
    .out_ready     (out_ready),
    .err_timeout   (err_timeout),
    .err_overrun   (err_overrun)
  );

  always #5 clk = ~clk;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  assign mac_out_ready = mac_model | spur;

  // MAC model: result valid lat cycles after the launch cycle
  always @(negedge clk) begin
    mac_model = 1'b0;
    if (mac_cnt > 0) begin
      mac_cnt = mac_cnt - 1;
      if (mac_cnt == 0) mac_model = 1'b1;
    end
    if (mac_in_ready) mac_cnt = lat_tbl[node_sel];
  end

  // Event monitor
  always @(negedge clk) begin
    int r;
    r = cyc - t0;
    if (mac_in_ready && n_launch < 8) begin
      launch_cyc[n_launch]  = r;
      launch_node[n_launch] = int'(node_sel);
      n_launch++;
    end
    if (wr_en != 4'b0000 && n_wr < 8) begin
      wr_cyc[n_wr] = r;
      wr_val[n_wr] = int'(wr_en);
      n_wr++;
    end
    if (out_ready) begin
      out_cyc = r;
      n_out++;
    end
    if (err_timeout && to_cyc < 0) to_cyc = r;
    if (!busy && r >= 1 && busy_low < 0) busy_low = r;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat_tbl[0] = l0; lat_tbl[1] = l1; lat_tbl[2] = l2; lat_tbl[3] = l3;
  endtask

  // One pass: in_ready at relative cycle 0 (and at ovr_at), spurious MAC
  // result for the first spur_n cycles, reset pulse at rst_at.
  task automatic run_pass(input int ncyc, input int ovr_at, input int spur_n, input int rst_at);
    n_launch = 0; n_wr = 0; n_out = 0; out_cyc = -1; to_cyc = -1; busy_low = -1;
    t0 = cyc + 1;
    for (int r = 0; r < ncyc; r++) begin
      @(negedge clk);
      in_ready = (r == 0) || (r == ovr_at);
      spur     = (r < spur_n);
      if (r == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_busy", busy, 0);
        check_eq("rst_async_mac_in", mac_in_ready, 0);
        check_eq("rst_async_node_sel", node_sel, 0);
        check_eq("rst_async_wr_en", wr_en, 0);
        check_eq("rst_async_out", out_ready, 0);
        check_eq("rst_async_overrun", err_overrun, 0);
      end else if (r == rst_at + 1) begin
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    in_ready = 1'b0;
    spur     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_ready = 1'b0;
    set_lat(1, 1, 1, 1);
    n_launch = 0; n_wr = 0; n_out = 0; out_cyc = -1; to_cyc = -1; busy_low = -1;
    repeat (2) @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_wr_en", wr_en, 0);
    check_eq("reset_node_sel", node_sel, 0);
    check_eq("reset_errs", {err_timeout, err_overrun, out_ready, mac_in_ready}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal pass, 1-cycle MAC
    set_lat(1, 1, 1, 1);
    run_pass(18, -1, 0, -1);
    check_eq("nom_n_launch", n_launch, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("nom_launch_cyc", launch_cyc[i], 1 + 3 * i);
      check_eq("nom_launch_node", launch_node[i], i);
      check_eq("nom_wr_cyc", wr_cyc[i], 3 + 3 * i);
      check_eq("nom_wr_val", wr_val[i], 1 << i);
    end
    check_eq("nom_out_cyc", out_cyc, 13);
    check_eq("nom_n_out", n_out, 1);
    check_eq("nom_busy_low", busy_low, 14);
    check_eq("nom_errs", {err_timeout, err_overrun}, 0);

    // Node1 latency 5
    set_lat(1, 5, 1, 1);
    run_pass(22, -1, 0, -1);
    check_eq("var_wr1_cyc", wr_cyc[1], 10);
    check_eq("var_wr1_val", wr_val[1], 2);
    check_eq("var_out_cyc", out_cyc, 17);
    check_eq("var_errs", {err_timeout, err_overrun}, 0);

    // Node2 never returns
    set_lat(1, 1, 0, 1);
    run_pass(30, -1, 0, -1);
    check_eq("to_rise_cyc", to_cyc, 24);
    check_eq("to_n_wr", n_wr, 2);
    check_eq("to_n_out", n_out, 0);
    check_eq("to_n_launch", n_launch, 3);
    check_eq("to_busy_low", busy_low, 24);
    check_eq("to_flag_sticky", err_timeout, 1);

    // Recovery pass clears the timeout flag
    set_lat(1, 1, 1, 1);
    run_pass(18, -1, 0, -1);
    check_eq("rec_err_timeout", err_timeout, 0);
    check_eq("rec_out_cyc", out_cyc, 13);
    check_eq("rec_n_wr", n_wr, 4);

    // Overrun at cycle 5
    run_pass(18, 5, 0, -1);
    check_eq("ovr_flag", err_overrun, 1);
    check_eq("ovr_out_cyc", out_cyc, 13);
    check_eq("ovr_n_out", n_out, 1);
    check_eq("ovr_launch3", launch_cyc[3], 10);
    check_eq("ovr_n_launch", n_launch, 4);

    // Reset during node1 WAIT
    set_lat(1, 5, 1, 1);
    run_pass(20, -1, 0, 5);
    check_eq("rst_n_out", n_out, 0);
    check_eq("rst_n_wr", n_wr, 1);
    check_eq("rst_n_launch", n_launch, 2);
    check_eq("rst_idle_busy", busy, 0);

    // Spurious result in IDLE only
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      spur = 1'b1;
      #1;
      check_eq("spur_idle_wr_en", wr_en, 0);
      check_eq("spur_idle_busy", busy, 0);
    end
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    check_eq("spur_idle_after_busy", busy, 0);

    // Spurious result in IDLE and ISSUE; node0 real latency 3
    set_lat(3, 1, 1, 1);
    run_pass(20, -1, 2, -1);
    check_eq("spur_wr0_cyc", wr_cyc[0], 5);
    check_eq("spur_out_cyc", out_cyc, 15);
    check_eq("spur_n_wr", n_wr, 4);
    check_eq("spur_errs", {err_timeout, err_overrun}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
